// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants and state encoding for the memory stage
package mem_pkg;

   // funct3 encodings of load/store access size
   localparam logic [2:0] SIZE_B  = 3'b000;
   localparam logic [2:0] SIZE_H  = 3'b001;
   localparam logic [2:0] SIZE_W  = 3'b010;
   localparam logic [2:0] SIZE_BU = 3'b100;
   localparam logic [2:0] SIZE_HU = 3'b101;

   // writeback exception cause codes
   localparam logic [1:0] CAUSE_NONE             = 2'b00;
   localparam logic [1:0] CAUSE_MISALIGNED_LOAD  = 2'b01;
   localparam logic [1:0] CAUSE_MISALIGNED_STORE = 2'b10;
   localparam logic [1:0] CAUSE_ILLEGAL_SIZE     = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_WAIT = 2'b10
   } state_t;

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - selects the addressed lane of a read word and extends it
module load_align
   import mem_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr,
   input  logic [2:0]  size,
   output logic [31:0] result
);

   logic [31:0] shifted;

   // shift the addressed byte/halfword down to bit 0, then extend by size
   always_comb begin
      shifted = rdata >> {addr, 3'b000};
      case (size)
         SIZE_B:  result = {{24{shifted[7]}}, shifted[7:0]};
         SIZE_H:  result = {{16{shifted[15]}}, shifted[15:0]};
         SIZE_BU: result = {24'd0, shifted[7:0]};
         SIZE_HU: result = {16'd0, shifted[15:0]};
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - load/store stage with single-outstanding data bus and writeback register
module memory_stage
   import mem_pkg::*;
#(
   parameter logic [31:0] RESET_PC_UNUSED = 32'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        ex_valid,
   output logic        ex_ready,
   input  logic [31:0] ex_alu_result,
   input  logic [31:0] ex_store_data,
   input  logic        ex_mem_load,
   input  logic        ex_mem_store,
   input  logic [2:0]  ex_mem_size,
   input  logic [4:0]  ex_rd,
   input  logic        ex_rd_write,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_strb,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic        wb_rd_write,
   output logic [31:0] wb_data,
   output logic        wb_exception,
   output logic [1:0]  wb_cause
);

   logic [31:0] unused_param;
   assign unused_param = RESET_PC_UNUSED;

   state_t      state;
   logic        pend_load;
   logic [2:0]  pend_size;
   logic [1:0]  pend_lo;
   logic [4:0]  pend_rd;
   logic        pend_rd_write;
   logic        killed;

   logic        accept;
   logic        is_mem;
   logic        size_ok;
   logic        misaligned;
   logic [1:0]  fault_cause;
   logic [31:0] st_wdata;
   logic [3:0]  st_strb;
   logic [31:0] load_result;

   // flush blocks the handshake itself so execute never sees a dropped transfer
   assign ex_ready = (state == ST_IDLE) && !flush;
   assign accept   = ex_valid && ex_ready;
   assign is_mem   = ex_mem_load || ex_mem_store;

   // classify the offered access: legal size, alignment, and resulting cause
   always_comb begin
      size_ok = 1'b0;
      if (ex_mem_load) begin
         case (ex_mem_size)
            SIZE_B, SIZE_H, SIZE_W, SIZE_BU, SIZE_HU: size_ok = 1'b1;
            default:                                  size_ok = 1'b0;
         endcase
      end else if (ex_mem_store) begin
         case (ex_mem_size)
            SIZE_B, SIZE_H, SIZE_W: size_ok = 1'b1;
            default:                size_ok = 1'b0;
         endcase
      end
      misaligned = ((ex_mem_size[1:0] == 2'b01) && ex_alu_result[0]) ||
                   ((ex_mem_size[1:0] == 2'b10) && (ex_alu_result[1:0] != 2'b00));
      fault_cause = CAUSE_NONE;
      if (is_mem) begin
         if (!size_ok)
            fault_cause = CAUSE_ILLEGAL_SIZE;
         else if (misaligned)
            fault_cause = ex_mem_load ? CAUSE_MISALIGNED_LOAD : CAUSE_MISALIGNED_STORE;
      end
   end

   // replicate store data across lanes and enable only the addressed bytes
   always_comb begin
      case (ex_mem_size[1:0])
         2'b00: begin
            st_wdata = {4{ex_store_data[7:0]}};
            st_strb  = 4'b0001 << ex_alu_result[1:0];
         end
         2'b01: begin
            st_wdata = {2{ex_store_data[15:0]}};
            st_strb  = 4'b0011 << ex_alu_result[1:0];
         end
         default: begin
            st_wdata = ex_store_data;
            st_strb  = 4'b1111;
         end
      endcase
   end

   load_align u_load_align (
      .rdata  (mem_rdata),
      .addr   (pend_lo),
      .size   (pend_size),
      .result (load_result)
   );

   // stage FSM: accept, bus request/grant/response and registered writeback
   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= ST_IDLE;
         mem_req       <= 1'b0;
         mem_we        <= 1'b0;
         mem_addr      <= 32'd0;
         mem_wdata     <= 32'd0;
         mem_strb      <= 4'd0;
         wb_valid      <= 1'b0;
         wb_rd         <= 5'd0;
         wb_rd_write   <= 1'b0;
         wb_data       <= 32'd0;
         wb_exception  <= 1'b0;
         wb_cause      <= CAUSE_NONE;
         pend_load     <= 1'b0;
         pend_size     <= 3'd0;
         pend_lo       <= 2'd0;
         pend_rd       <= 5'd0;
         pend_rd_write <= 1'b0;
         killed        <= 1'b0;
      end else begin
         wb_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (!is_mem || (fault_cause != CAUSE_NONE)) begin
                     wb_valid     <= 1'b1;
                     wb_rd        <= ex_rd;
                     wb_rd_write  <= ex_rd_write && !is_mem;
                     wb_data      <= ex_alu_result;
                     wb_exception <= is_mem;
                     wb_cause     <= fault_cause;
                  end else begin
                     state         <= ST_REQ;
                     mem_req       <= 1'b1;
                     mem_we        <= ex_mem_store;
                     mem_addr      <= {ex_alu_result[31:2], 2'b00};
                     mem_wdata     <= ex_mem_store ? st_wdata : 32'd0;
                     mem_strb      <= ex_mem_store ? st_strb : 4'b1111;
                     pend_load     <= ex_mem_load;
                     pend_size     <= ex_mem_size;
                     pend_lo       <= ex_alu_result[1:0];
                     pend_rd       <= ex_rd;
                     pend_rd_write <= ex_rd_write;
                     killed        <= 1'b0;
                  end
               end
            end
            ST_REQ: begin
               if (flush)
                  killed <= 1'b1;
               if (mem_gnt) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  if (pend_load) begin
                     state <= ST_WAIT;
                  end else begin
                     state <= ST_IDLE;
                     if (!killed && !flush) begin
                        wb_valid     <= 1'b1;
                        wb_rd        <= pend_rd;
                        wb_rd_write  <= 1'b0;
                        wb_data      <= {mem_addr[31:2], pend_lo};
                        wb_exception <= 1'b0;
                        wb_cause     <= CAUSE_NONE;
                     end
                  end
               end
            end
            ST_WAIT: begin
               if (flush)
                  killed <= 1'b1;
               if (mem_rvalid) begin
                  state <= ST_IDLE;
                  if (!killed && !flush) begin
                     wb_valid     <= 1'b1;
                     wb_rd        <= pend_rd;
                     wb_rd_write  <= pend_rd_write;
                     wb_data      <= load_result;
                     wb_exception <= 1'b0;
                     wb_cause     <= CAUSE_NONE;
                  end
               end
            end
            default: begin
               state   <= ST_IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - self-checking bench for memory_stage with a transaction-level model
module tb_memory_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        flush = 1'b0;
   logic        ex_valid = 1'b0;
   logic        ex_ready;
   logic [31:0] ex_alu_result = 32'd0;
   logic [31:0] ex_store_data = 32'd0;
   logic        ex_mem_load = 1'b0;
   logic        ex_mem_store = 1'b0;
   logic [2:0]  ex_mem_size = 3'd0;
   logic [4:0]  ex_rd = 5'd0;
   logic        ex_rd_write = 1'b0;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_strb;
   logic        mem_gnt = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = 32'd0;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic        wb_rd_write;
   logic [31:0] wb_data;
   logic        wb_exception;
   logic [1:0]  wb_cause;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   memory_stage dut (
      .clk           (clk),
      .reset         (reset),
      .flush         (flush),
      .ex_valid      (ex_valid),
      .ex_ready      (ex_ready),
      .ex_alu_result (ex_alu_result),
      .ex_store_data (ex_store_data),
      .ex_mem_load   (ex_mem_load),
      .ex_mem_store  (ex_mem_store),
      .ex_mem_size   (ex_mem_size),
      .ex_rd         (ex_rd),
      .ex_rd_write   (ex_rd_write),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_strb      (mem_strb),
      .mem_gnt       (mem_gnt),
      .mem_rvalid    (mem_rvalid),
      .mem_rdata     (mem_rdata),
      .wb_valid      (wb_valid),
      .wb_rd         (wb_rd),
      .wb_rd_write   (wb_rd_write),
      .wb_data       (wb_data),
      .wb_exception  (wb_exception),
      .wb_cause      (wb_cause)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // expected cause: 0 none, 1 misaligned load, 2 misaligned store, 3 illegal size
   function automatic logic [1:0] model_cause(input logic ld, input logic st,
                                              input logic [2:0] sz, input logic [31:0] addr);
      int nbytes;
      nbytes = 1 << (sz % 4);
      if (ld) begin
         if (!(sz inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 2'd3;
         if ((addr % nbytes) != 0) return 2'd1;
      end else if (st) begin
         if (sz > 3'd2) return 2'd3;
         if ((addr % nbytes) != 0) return 2'd2;
      end
      return 2'd0;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] addr,
                                              input logic [2:0] sz);
      logic [31:0] sh;
      logic [31:0] b;
      logic [31:0] h;
      sh = rdata >> (8 * (addr % 4));
      b  = sh % 256;
      h  = sh % 65536;
      case (sz)
         3'd0:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
         3'd1:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
         3'd4:    return b;
         3'd5:    return h;
         default: return rdata;
      endcase
   endfunction

   function automatic logic [31:0] model_wdata(input logic [31:0] d, input logic [2:0] sz);
      if (sz == 3'd0) return (d % 256) * 32'h01010101;
      if (sz == 3'd1) return (d % 65536) * 32'h00010001;
      return d;
   endfunction

   function automatic logic [3:0] model_strb(input logic st, input logic [2:0] sz,
                                             input logic [31:0] addr);
      int nbytes;
      if (!st || sz == 3'd2) return 4'hF;
      nbytes = (sz == 3'd0) ? 1 : 2;
      return 4'((2 ** nbytes - 1) * (2 ** (addr % 4)));
   endfunction

   task automatic drive_op(input logic ld, input logic st, input logic [2:0] sz,
                           input logic [31:0] addr, input logic [31:0] sd,
                           input logic [4:0] rd, input logic rdw);
      ex_valid      = 1'b1;
      ex_mem_load   = ld;
      ex_mem_store  = st;
      ex_mem_size   = sz;
      ex_alu_result = addr;
      ex_store_data = sd;
      ex_rd         = rd;
      ex_rd_write   = rdw;
   endtask

   // one complete instruction with bus latencies gd (grant) and rvd (response)
   task automatic do_op(input logic ld, input logic st, input logic [2:0] sz,
                        input logic [31:0] addr, input logic [31:0] sd,
                        input logic [4:0] rd, input logic rdw,
                        input int gd, input int rvd, input logic [31:0] rdata);
      logic [1:0] cause;
      cause = model_cause(ld, st, sz, addr);
      chk("ready_idle", ex_ready, 1);
      drive_op(ld, st, sz, addr, sd, rd, rdw);
      step();
      ex_valid = 1'b0;
      if (!ld && !st) begin
         chk("alu_wb_valid", wb_valid, 1);
         chk("alu_wb_data", wb_data, addr);
         chk("alu_wb_rd", wb_rd, rd);
         chk("alu_wb_rd_write", wb_rd_write, rdw);
         chk("alu_no_exc", wb_exception, 0);
         chk("alu_no_req", mem_req, 0);
      end else if (cause != 2'd0) begin
         chk("fault_wb_valid", wb_valid, 1);
         chk("fault_exc", wb_exception, 1);
         chk("fault_cause", wb_cause, cause);
         chk("fault_data", wb_data, addr);
         chk("fault_rd_write", wb_rd_write, 0);
         chk("fault_no_req", mem_req, 0);
      end else begin
         chk("req_high", mem_req, 1);
         chk("req_we", mem_we, st);
         chk("req_addr", mem_addr, addr & 32'hFFFFFFFC);
         chk("req_strb", mem_strb, model_strb(st, sz, addr));
         if (st) chk("req_wdata", mem_wdata, model_wdata(sd, sz));
         chk("req_not_ready", ex_ready, 0);
         for (int i = 0; i < gd; i++) begin
            step();
            chk("req_held", mem_req, 1);
            chk("req_addr_held", mem_addr, addr & 32'hFFFFFFFC);
            chk("req_strb_held", mem_strb, model_strb(st, sz, addr));
            chk("req_no_wb", wb_valid, 0);
         end
         mem_gnt = 1'b1;
         step();
         mem_gnt = 1'b0;
         chk("gnt_req_drop", mem_req, 0);
         if (st) begin
            chk("st_wb_valid", wb_valid, 1);
            chk("st_rd_write", wb_rd_write, 0);
            chk("st_no_exc", wb_exception, 0);
         end else begin
            chk("ld_gnt_no_wb", wb_valid, 0);
            for (int i = 0; i < rvd; i++) begin
               step();
               chk("wait_no_wb", wb_valid, 0);
               chk("wait_not_ready", ex_ready, 0);
            end
            mem_rvalid = 1'b1;
            mem_rdata  = rdata;
            step();
            mem_rvalid = 1'b0;
            chk("ld_wb_valid", wb_valid, 1);
            chk("ld_wb_data", wb_data, model_load(rdata, addr, sz));
            chk("ld_wb_rd", wb_rd, rd);
            chk("ld_wb_rd_write", wb_rd_write, rdw);
            chk("ld_no_exc", wb_exception, 0);
         end
      end
      step();
      chk("wb_pulse", wb_valid, 0);
   endtask

   initial begin
      // reset state
      step();
      step();
      chk("rst_mem_req", mem_req, 0);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_mem_strb", mem_strb, 0);
      chk("rst_wb_data", wb_data, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_wb_cause", wb_cause, 0);
      reset = 1'b1;
      step();
      chk("rst_ready", ex_ready, 1);

      // pass-through at full throughput
      for (int i = 1; i <= 3; i++) begin
         drive_op(1'b0, 1'b0, 3'd0, 32'(i), 32'd0, 5'd3, 1'b1);
         step();
         chk("pt_valid", wb_valid, 1);
         chk("pt_data", wb_data, 32'(i));
         chk("pt_no_req", mem_req, 0);
      end
      ex_valid = 1'b0;
      step();
      chk("pt_end", wb_valid, 0);

      // directed memory ops and faults
      do_op(1'b0, 1'b1, 3'd0, 32'h1003, 32'h000000A5, 5'd4, 1'b1, 2, 0, 32'd0);
      do_op(1'b1, 1'b0, 3'd0, 32'h2001, 32'd0, 5'd5, 1'b1, 1, 3, 32'h1234F6AB);
      do_op(1'b1, 1'b0, 3'd5, 32'h2002, 32'd0, 5'd6, 1'b1, 0, 0, 32'h1234F6AB);
      do_op(1'b1, 1'b0, 3'd2, 32'h3002, 32'd0, 5'd7, 1'b1, 0, 0, 32'd0);
      do_op(1'b0, 1'b1, 3'd4, 32'h3000, 32'd0, 5'd8, 1'b0, 0, 0, 32'd0);
      do_op(1'b0, 1'b1, 3'd1, 32'h4002, 32'h0000BEEF, 5'd9, 1'b0, 0, 0, 32'd0);

      // flush while a load waits for grant
      drive_op(1'b1, 1'b0, 3'd2, 32'h5000, 32'd0, 5'd10, 1'b1);
      step();
      ex_valid = 1'b0;
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("fl_req_held", mem_req, 1);
      chk("fl_no_wb", wb_valid, 0);
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      chk("fl_req_drop", mem_req, 0);
      chk("fl_gnt_no_wb", wb_valid, 0);
      mem_rvalid = 1'b1;
      mem_rdata = 32'hCAFEF00D;
      step();
      mem_rvalid = 1'b0;
      chk("fl_killed_no_wb", wb_valid, 0);
      chk("fl_ready_after", ex_ready, 1);
      do_op(1'b0, 1'b0, 3'd0, 32'h00000077, 32'd0, 5'd11, 1'b1, 0, 0, 32'd0);

      // reset while waiting for read data
      drive_op(1'b1, 1'b0, 3'd2, 32'h6000, 32'd0, 5'd12, 1'b1);
      step();
      ex_valid = 1'b0;
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      chk("wait_entered", ex_ready, 0);
      reset = 1'b0;
      step();
      reset = 1'b1;
      chk("rw_req", mem_req, 0);
      chk("rw_wb_valid", wb_valid, 0);
      chk("rw_ready", ex_ready, 1);
      chk("rw_strb", mem_strb, 0);
      mem_rvalid = 1'b1;
      mem_rdata = 32'h11111111;
      step();
      mem_rvalid = 1'b0;
      chk("stray_rvalid", wb_valid, 0);
      chk("stray_no_req", mem_req, 0);

      // randomized instruction mix against the model
      for (int n = 0; n < 60; n++) begin
         int typ;
         logic [31:0] a;
         typ = int'($urandom_range(0, 2));
         a = $urandom;
         if ($urandom_range(0, 1) == 1) a = a & 32'hFFFFFFFC;
         do_op(typ == 1, typ == 2, 3'($urandom_range(0, 7)), a, $urandom,
               5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
